// File: rtl/tile_serializer_if.sv
// Planar tile word handshake into the serializer holding register.
// Producer drives valid/data/flip/swap; serializer returns ready.
interface tile_serializer_if #(
   parameter int PLANES = 4,
   parameter int PIXELS = 8
) ();

   logic                       in_valid;
   logic                       in_ready;
   logic [PLANES*PIXELS-1:0]   in_data;
   logic                       in_flip;
   logic                       in_swap;

   modport master (
      output in_valid,
      output in_data,
      output in_flip,
      output in_swap,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_flip,
      input  in_swap,
      output in_ready
   );

endinterface

// File: rtl/tile_serializer.sv
// Bitplane-to-pixel serializer: one-deep hold register feeding a shift
// stage that emits LANES pixel indices per enabled clock.
module tile_serializer #(
   parameter int PLANES = 4,
   parameter int PIXELS = 8,
   parameter int LANES  = 2
) (
   input  logic                    clk,
   input  logic                    nreset,
   input  logic                    ce,
   tile_serializer_if.slave        in_if,
   output logic [LANES*PLANES-1:0] pix,
   output logic [LANES-1:0]        opaque,
   output logic                    out_valid,
   output logic                    out_last
);

   localparam int STEPS = PIXELS / LANES;
   localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam int DW    = PLANES * PIXELS;
   localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

   typedef struct packed {
      logic [DW-1:0] data;
      logic          flip;
      logic          swap;
   } word_t;

   word_t          hold_q;
   word_t          hold_d;
   logic           hold_vld_q;
   logic           hold_vld_d;
   word_t          shift_q;
   word_t          shift_d;
   logic           shift_vld_q;
   logic           shift_vld_d;
   logic [SW-1:0]  step_q;
   logic [SW-1:0]  step_d;

   logic           accept;
   logic           drain;
   logic           at_last;
   word_t          in_word;

   logic [LANES*PLANES-1:0] pix_c;

   assign in_word.data = in_if.in_data;
   assign in_word.flip = in_if.in_flip;
   assign in_word.swap = in_if.in_swap;

   assign at_last      = (step_q == LAST);
   assign accept       = in_if.in_valid && !hold_vld_q;
   assign drain        = ce && (!shift_vld_q || at_last);
   assign in_if.in_ready = !hold_vld_q;

   // Drain uses the pre-edge hold; an accept only happens when hold was empty.
   always_comb begin
      hold_d      = hold_q;
      hold_vld_d  = hold_vld_q;
      shift_d     = shift_q;
      shift_vld_d = shift_vld_q;
      step_d      = step_q;
      if (drain) begin
         shift_d     = hold_q;
         shift_vld_d = hold_vld_q;
         step_d      = '0;
         hold_vld_d  = 1'b0;
      end else if (ce && shift_vld_q) begin
         step_d = step_q + 1'b1;
      end
      if (accept) begin
         hold_d     = in_word;
         hold_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         hold_q      <= '0;
         hold_vld_q  <= 1'b0;
         shift_q     <= '0;
         shift_vld_q <= 1'b0;
         step_q      <= '0;
      end else begin
         hold_q      <= hold_d;
         hold_vld_q  <= hold_vld_d;
         shift_q     <= shift_d;
         shift_vld_q <= shift_vld_d;
         step_q      <= step_d;
      end
   end

   // Pixel pos in the word, mirrored by flip; lane index mirrored by swap.
   always_comb begin
      int pos;
      int x;
      int l;
      pix_c = '0;
      pos   = 0;
      x     = 0;
      l     = 0;
      for (int k = 0; k < LANES; k++) begin
         pos = int'(step_q) * LANES + k;
         x   = shift_q.flip ? (PIXELS - 1 - pos) : pos;
         l   = shift_q.swap ? (LANES - 1 - k) : k;
         for (int p = 0; p < PLANES; p++) begin
            pix_c[l*PLANES + p] = shift_q.data[p*PIXELS + x];
         end
      end
      if (!shift_vld_q) begin
         pix_c = '0;
      end
   end

   always_comb begin
      opaque = '0;
      for (int l = 0; l < LANES; l++) begin
         opaque[l] = |pix_c[l*PLANES +: PLANES];
      end
   end

   assign pix       = pix_c;
   assign out_valid = shift_vld_q;
   assign out_last  = shift_vld_q && at_last;

endmodule
